mips_processor: RTL and testbench



---
 rtl/mips_pkg.sv | 49 ++++
 rtl/byte_memory.sv | 30 +++
 rtl/mips_processor_ifu.sv | 38 +++
 rtl/mips_processor_regfile.sv | 28 ++
 rtl/mips_processor.sv | 136 +++++++++++++
 tb/tb_mips_processor.sv | 334 +++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mips_pkg.sv
// Shared encodings and control bundle for the single-cycle MIPS-subset core.
// Opcode/funct values follow the standard MIPS encodings plus custom BMN.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BMN   = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [4:0] REG_A0 = 5'd4;
  localparam logic [4:0] REG_A1 = 5'd5;
  localparam logic [4:0] REG_T0 = 5'd8;
  localparam logic [4:0] REG_S0 = 5'd16;
  localparam logic [4:0] REG_S1 = 5'd17;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  typedef struct packed {
    logic    reg_write;
    logic    reg_dst;
    logic    alu_src;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    logic    jump;
    logic    bmn;
    alu_op_t alu_op;
  } ctrl_t;

  function automatic logic [31:0] sext16(logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/byte_memory.sv
// 1024x8 little-endian byte array with one word-aligned read/write port.
// Program loaders write the array hierarchically, so it is a plain always.
module byte_memory (
  input  logic        clk,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [7:0] bytes [0:1023] = '{default: 8'h00};
  logic [9:0] base;

  assign base = {addr, 2'b00};

  assign rdata = {bytes[base + 10'd3],
                  bytes[base + 10'd2],
                  bytes[base + 10'd1],
                  bytes[base]};

  always @(posedge clk) begin
    if (we) begin
      bytes[base]         <= wdata[7:0];
      bytes[base + 10'd1] <= wdata[15:8];
      bytes[base + 10'd2] <= wdata[23:16];
      bytes[base + 10'd3] <= wdata[31:24];
    end
  end

endmodule

// File: rtl/mips_processor_ifu.sv
// Instruction fetch: PC register and read-only instruction memory.
// Fetch address wraps modulo 1024 by using only PC[9:2].
module mips_processor_imem (
  input  logic        clk,
  input  logic [7:0]  addr,
  output logic [31:0] instr
);

  byte_memory storage (
    .clk   (clk),
    .we    (1'b0),
    .addr  (addr),
    .wdata (32'd0),
    .rdata (instr)
  );

endmodule

module mips_processor_ifu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= '0;
    else       pc <= pc_next;
  end

  mips_processor_imem imemory (
    .clk   (clk),
    .addr  (pc[9:2]),
    .instr (instr)
  );

endmodule

// File: rtl/mips_processor_regfile.sv
// 32x32 register file: two combinational reads, one write, $0 hardwired.
// Asynchronous reset clears every entry.
module mips_processor_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] registers [0:31];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we && wa != 5'd0) begin
      registers[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : registers[ra2];

endmodule

// File: rtl/mips_processor.sv
// Single-cycle MIPS-subset core with the custom BMN instruction.
// Fetch, decode, execute, memory and write-back all finish in one clk.
module mips_processor (
  input logic clk,
  input logic reset
);

  import mips_pkg::*;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic [31:0] imm;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic [31:0] mem_rdata;
  logic [31:0] wb_data;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  wa;
  logic [25:0] target;
  logic [7:0]  mem_addr;
  logic        taken;
  ctrl_t       ctrl;

  mips_processor_ifu IFU (
    .clk     (clk),
    .reset   (reset),
    .pc_next (pc_next),
    .pc      (pc),
    .instr   (instr)
  );

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign target = instr[25:0];
  assign imm    = sext16(instr[15:0]);

  always_comb begin
    ctrl = '0;
    ctrl.alu_op = ALU_ADD;
    unique case (1'b1)
      opcode == OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        unique case (1'b1)
          funct == FN_ADD: ctrl.alu_op = ALU_ADD;
          funct == FN_SUB: ctrl.alu_op = ALU_SUB;
          funct == FN_AND: ctrl.alu_op = ALU_AND;
          funct == FN_OR:  ctrl.alu_op = ALU_OR;
          funct == FN_SLT: ctrl.alu_op = ALU_SLT;
          default:         ctrl.reg_write = 1'b0;
        endcase
      end
      opcode == OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      opcode == OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      opcode == OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      opcode == OP_BEQ: ctrl.branch = 1'b1;
      opcode == OP_J:   ctrl.jump   = 1'b1;
      opcode == OP_BMN: ctrl.bmn    = 1'b1;
      default: ;
    endcase
  end

  mips_processor_regfile registers (
    .clk   (clk),
    .reset (reset),
    .we    (ctrl.reg_write & ~reset),
    .ra1   (rs),
    .ra2   (rt),
    .wa    (wa),
    .wd    (wb_data),
    .rd1   (rs_val),
    .rd2   (rt_val)
  );

  assign alu_b = ctrl.alu_src ? imm : rt_val;

  always_comb begin
    alu_res = '0;
    unique case (ctrl.alu_op)
      ALU_ADD: alu_res = rs_val + alu_b;
      ALU_SUB: alu_res = rs_val - alu_b;
      ALU_AND: alu_res = rs_val & alu_b;
      ALU_OR:  alu_res = rs_val | alu_b;
      ALU_SLT: alu_res = {31'd0, $signed(rs_val) < $signed(alu_b)};
      default: alu_res = '0;
    endcase
  end

  // BMN reads memory at R[rs] directly; loads/stores use the ALU sum
  assign mem_addr = ctrl.bmn ? rs_val[9:2] : alu_res[9:2];

  byte_memory dmemory (
    .clk   (clk),
    .we    (ctrl.mem_write & ~reset),
    .addr  (mem_addr),
    .wdata (rt_val),
    .rdata (mem_rdata)
  );

  assign wa      = ctrl.reg_dst ? rd : rt;
  assign wb_data = ctrl.mem_to_reg ? mem_rdata : alu_res;

  assign pc_plus4 = pc + 32'd4;
  assign taken    = (ctrl.branch && rs_val == rt_val) ||
                    (ctrl.bmn && mem_rdata[31]);

  always_comb begin
    pc_next = pc_plus4;
    if (ctrl.jump)
      pc_next = {pc_plus4[31:28], target, 2'b00};
    else if (taken)
      pc_next = pc_plus4 + {imm[29:0], 2'b00};
  end

endmodule

// File: tb/tb_mips_processor.sv
// Self-checking bench for mips_processor: ALU vector table, directed
// programs for BMN/branch/jump/reset, and random programs vs an ISA model.
module tb_mips_processor;

  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mips_processor dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  logic [31:0] prog [0:255];
  logic [31:0] mr   [0:31];
  logic [7:0]  mm   [0:1023];
  logic [31:0] mpc;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] r_ins(logic [4:0] rs, logic [4:0] rt,
                                        logic [4:0] rd, logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, logic [4:0] rs,
                                        logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_ins(logic [25:0] a);
    return {OP_J, a};
  endfunction

  function automatic logic [31:0] dword(int a);
    return {dut.dmemory.bytes[a+3], dut.dmemory.bytes[a+2],
            dut.dmemory.bytes[a+1], dut.dmemory.bytes[a]};
  endfunction

  function automatic logic [31:0] mrd(logic [31:0] a);
    logic [9:0] x;
    x = a[9:0];
    return {mm[x + 10'd3], mm[x + 10'd2], mm[x + 10'd1], mm[x]};
  endfunction

  task automatic mst(logic [31:0] a, logic [31:0] v);
    logic [9:0] x;
    x = a[9:0];
    for (int k = 0; k < 4; k++) mm[x + 10'(k)] = v[8*k +: 8];
  endtask

  task automatic mwr(logic [4:0] r, logic [31:0] v);
    if (r != 5'd0) mr[r] = v;
  endtask

  // Instruction-set level model of one retired instruction
  task automatic model_step();
    logic [31:0] ins, a, b, simm, pc4, nxt, m;
    ins  = prog[mpc[9:2]];
    a    = mr[ins[25:21]];
    b    = mr[ins[20:16]];
    simm = 32'($signed(ins[15:0]));
    pc4  = mpc + 32'd4;
    nxt  = pc4;
    case (ins[31:26])
      OP_RTYPE:
        case (ins[5:0])
          FN_ADD: mwr(ins[15:11], a + b);
          FN_SUB: mwr(ins[15:11], a - b);
          FN_AND: mwr(ins[15:11], a & b);
          FN_OR:  mwr(ins[15:11], a | b);
          FN_SLT: mwr(ins[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
          default: ;
        endcase
      OP_ADDI: mwr(ins[20:16], a + simm);
      OP_LW:   mwr(ins[20:16], mrd(a + simm));
      OP_SW:   mst(a + simm, b);
      OP_BEQ:  if (a == b) nxt = pc4 + simm * 4;
      OP_J:    nxt = {pc4[31:28], ins[25:0], 2'b00};
      OP_BMN: begin
        m = mrd(a);
        if (m[31]) nxt = pc4 + simm * 4;
      end
      default: ;
    endcase
    mpc = nxt;
  endtask

  task automatic set_word(int a, logic [31:0] v);
    for (int k = 0; k < 4; k++) begin
      dut.dmemory.bytes[a+k] = v[8*k +: 8];
      mm[a+k] = v[8*k +: 8];
    end
  endtask

  task automatic begin_prog();
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) prog[i] = '0;
    for (int i = 0; i < 1024; i++) begin
      dut.dmemory.bytes[i] = 8'h00;
      mm[i] = 8'h00;
    end
  endtask

  task automatic launch();
    for (int i = 0; i < 256; i++)
      for (int k = 0; k < 4; k++)
        dut.IFU.imemory.storage.bytes[4*i+k] = prog[i][8*k +: 8];
    for (int r = 0; r < 32; r++) mr[r] = '0;
    mpc = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 5))
      0: return 5'd0;
      1: return REG_A0;
      2: return REG_A1;
      3: return REG_T0;
      4: return REG_S0;
      default: return REG_S1;
    endcase
  endfunction

  function automatic logic [5:0] pick_fn();
    case ($urandom_range(0, 5))
      0: return FN_ADD;
      1: return FN_SUB;
      2: return FN_AND;
      3: return FN_OR;
      4: return FN_SLT;
      default: return 6'h27;
    endcase
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [4:0] a, b, c;
    logic [15:0] off;
    a = pick_reg();
    b = pick_reg();
    c = pick_reg();
    off = 16'($urandom_range(0, 10)) - 16'd4;
    case ($urandom_range(0, 9))
      0, 1, 2: return r_ins(a, b, c, pick_fn());
      3, 4: return i_ins(OP_ADDI, a, b, 16'($urandom));
      5: return i_ins(OP_LW, 5'd0, b, 16'(4 * $urandom_range(0, 15)));
      6: return i_ins(OP_SW, 5'd0, b, 16'(4 * $urandom_range(0, 15)));
      7: return i_ins(OP_BEQ, a, b, off);
      8: return i_ins(OP_BMN, 5'd0, b, off);
      default:
        if ($urandom_range(0, 1) == 1) return j_ins(26'($urandom_range(0, 40)));
        else return {6'h3E, 26'($urandom)};
    endcase
  endfunction

  typedef struct {
    string       name;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs [9];
  logic [31:0] pc_seq [7];
  logic [31:0] acc;

  initial begin
    vecs[0] = '{"add",      FN_ADD, 32'd5,        32'd7,        32'd12};
    vecs[1] = '{"add_wrap", FN_ADD, 32'hFFFFFFFF, 32'd1,        32'd0};
    vecs[2] = '{"sub_neg",  FN_SUB, 32'd3,        32'd5,        32'hFFFFFFFE};
    vecs[3] = '{"and",      FN_AND, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000};
    vecs[4] = '{"or",       FN_OR,  32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF};
    vecs[5] = '{"slt_m1_1", FN_SLT, 32'hFFFFFFFF, 32'd1,        32'd1};
    vecs[6] = '{"slt_1_m1", FN_SLT, 32'd1,        32'hFFFFFFFF, 32'd0};
    vecs[7] = '{"slt_max",  FN_SLT, 32'h7FFFFFFF, 32'h80000000, 32'd0};
    vecs[8] = '{"bad_fn",   6'h27,  32'd1,        32'd2,        32'd0};

    // reset state
    @(posedge clk);
    @(negedge clk);
    check("reset_pc", dut.IFU.pc, 32'd0);
    acc = '0;
    for (int r = 0; r < 32; r++) acc |= dut.registers.registers[r];
    check("reset_regs", acc, 32'd0);

    // store program
    begin_prog();
    prog[0] = i_ins(OP_ADDI, 5'd0, REG_S0, 16'd4);
    prog[1] = i_ins(OP_ADDI, 5'd0, REG_S1, 16'd8);
    prog[2] = i_ins(OP_SW, 5'd0, REG_S0, 16'd8);
    launch();
    step(3);
    check("p1_s0", dut.registers.registers[REG_S0], 32'd4);
    check("p1_s1", dut.registers.registers[REG_S1], 32'd8);
    check("p1_mem8", dword(8), 32'd4);

    // ALU vector table
    for (int i = 0; i < 9; i++) begin
      begin_prog();
      set_word(0, vecs[i].a);
      set_word(4, vecs[i].b);
      prog[0] = i_ins(OP_LW, 5'd0, REG_T0, 16'd0);
      prog[1] = i_ins(OP_LW, 5'd0, REG_A1, 16'd4);
      prog[2] = r_ins(REG_T0, REG_A1, REG_A0, vecs[i].fn);
      prog[3] = i_ins(OP_SW, 5'd0, REG_A0, 16'd8);
      launch();
      step(4);
      check({vecs[i].name, "_reg"}, dut.registers.registers[REG_A0], vecs[i].exp);
      check({vecs[i].name, "_mem"}, dword(8), vecs[i].exp);
    end

    // bmn taken on a negative word
    begin_prog();
    set_word(16, 32'h80000000);
    prog[0] = i_ins(OP_ADDI, 5'd0, REG_T0, 16'd1);
    prog[1] = i_ins(OP_ADDI, 5'd0, REG_A1, 16'd2);
    prog[2] = i_ins(OP_ADDI, 5'd0, REG_S1, 16'd16);
    prog[3] = i_ins(OP_BMN, REG_S1, 5'd0, 16'd2);
    prog[4] = i_ins(OP_ADDI, 5'd0, REG_A1, 16'd99);
    prog[5] = i_ins(OP_ADDI, 5'd0, REG_A1, 16'd77);
    prog[6] = i_ins(OP_ADDI, 5'd0, REG_A0, 16'd4);
    launch();
    step(5);
    check("bmn_t_a0", dut.registers.registers[REG_A0], 32'd4);
    check("bmn_t_a1", dut.registers.registers[REG_A1], 32'd2);
    check("bmn_t_t0", dut.registers.registers[REG_T0], 32'd1);
    check("bmn_t_pc", dut.IFU.pc, 32'd28);

    // bmn not taken on a non-negative word
    begin_prog();
    set_word(16, 32'd24);
    prog[0] = i_ins(OP_ADDI, 5'd0, REG_A1, 16'd2);
    prog[1] = i_ins(OP_ADDI, 5'd0, REG_S1, 16'd16);
    prog[2] = i_ins(OP_BMN, REG_S1, 5'd0, 16'd3);
    prog[3] = i_ins(OP_LW, 5'd0, REG_S0, 16'd16);
    prog[4] = i_ins(OP_SW, 5'd0, REG_S0, 16'd12);
    prog[5] = j_ins(26'd8);
    prog[6] = i_ins(OP_ADDI, 5'd0, REG_A0, 16'd4);
    launch();
    step(6);
    check("bmn_n_s0", dut.registers.registers[REG_S0], 32'd24);
    check("bmn_n_mem12", dword(12), 32'd24);
    check("bmn_n_a0", dut.registers.registers[REG_A0], 32'd0);
    check("bmn_n_a1", dut.registers.registers[REG_A1], 32'd2);
    check("bmn_n_pc", dut.IFU.pc, 32'd32);

    // beq both ways, j, write to $0, negative addi
    begin_prog();
    prog[0]  = i_ins(OP_ADDI, 5'd0, REG_T0, 16'd5);
    prog[1]  = i_ins(OP_ADDI, 5'd0, 5'd0, 16'd7);
    prog[2]  = i_ins(OP_BEQ, REG_T0, 5'd0, 16'd3);
    prog[3]  = i_ins(OP_BEQ, 5'd0, 5'd0, 16'd2);
    prog[4]  = i_ins(OP_ADDI, 5'd0, REG_A0, 16'd1);
    prog[5]  = i_ins(OP_ADDI, 5'd0, REG_A0, 16'd2);
    prog[6]  = j_ins(26'd10);
    prog[10] = i_ins(OP_ADDI, 5'd0, REG_S0, 16'd9);
    prog[11] = i_ins(OP_ADDI, 5'd0, REG_S1, 16'hFFFD);
    pc_seq = '{32'd4, 32'd8, 32'd12, 32'd24, 32'd40, 32'd44, 32'd48};
    launch();
    for (int i = 0; i < 7; i++) begin
      step(1);
      check($sformatf("br_pc%0d", i), dut.IFU.pc, pc_seq[i]);
    end
    check("br_zero", dut.registers.registers[0], 32'd0);
    check("br_a0", dut.registers.registers[REG_A0], 32'd0);
    check("br_s0", dut.registers.registers[REG_S0], 32'd9);
    check("br_s1", dut.registers.registers[REG_S1], 32'hFFFFFFFD);

    // reset pulse mid-program
    begin_prog();
    prog[0] = i_ins(OP_ADDI, 5'd0, REG_S0, 16'd4);
    prog[1] = i_ins(OP_ADDI, 5'd0, REG_S1, 16'd8);
    prog[2] = i_ins(OP_SW, 5'd0, REG_S0, 16'd8);
    launch();
    step(2);
    #2 reset = 1'b1;
    #1;
    check("mid_pc", dut.IFU.pc, 32'd0);
    acc = '0;
    for (int r = 0; r < 32; r++) acc |= dut.registers.registers[r];
    check("mid_regs", acc, 32'd0);
    @(posedge clk);
    #1;
    check("mid_hold_pc", dut.IFU.pc, 32'd0);
    check("mid_hold_s0", dut.registers.registers[REG_S0], 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(3);
    check("mid_re_s0", dut.registers.registers[REG_S0], 32'd4);
    check("mid_re_s1", dut.registers.registers[REG_S1], 32'd8);
    check("mid_re_mem8", dword(8), 32'd4);

    // random programs against the ISA model
    for (int p = 0; p < 6; p++) begin
      begin_prog();
      for (int w = 0; w < 16; w++) set_word(4 * w, $urandom);
      for (int i = 0; i < 32; i++) prog[i] = rand_ins();
      launch();
      for (int e = 0; e < 40; e++) begin
        step(1);
        check($sformatf("rnd%0d_pc%0d", p, e), dut.IFU.pc, mpc);
      end
      for (int r = 0; r < 32; r++)
        check($sformatf("rnd%0d_r%0d", p, r), dut.registers.registers[r], mr[r]);
      for (int w = 0; w < 16; w++)
        check($sformatf("rnd%0d_m%0d", p, w), dword(4 * w), mrd(32'(4 * w)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
